// File: rtl/rb_read_port_arbiter_if.sv
// rb_read_port_arbiter_if: requester/register-bank read port bundle for the round-robin read arbiter
interface rb_read_port_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int DW    = 16,
  parameter int AW    = 3
);
  logic [N_REQ-1:0]    req;
  logic [N_REQ*AW-1:0] req_addr;
  logic [AW-1:0]       mux_sel;
  logic [DW-1:0]       mux_data;
  logic [N_REQ-1:0]    gnt;
  logic                rd_valid;
  logic [DW-1:0]       rd_data;
  logic [2:0]          rd_id;
  logic                busy;
  modport slave (
    input  req, req_addr, mux_data,
    output mux_sel, gnt, rd_valid, rd_data, rd_id, busy
  );
  modport master (
    output req, req_addr, mux_data,
    input  mux_sel, gnt, rd_valid, rd_data, rd_id, busy
  );
endinterface

// File: rtl/rb_read_port_arbiter.sv
// rb_read_port_arbiter: round-robin arbiter sequencing N_REQ requesters onto the register bank's single read mux
module rb_read_port_arbiter #(
  parameter int N_REQ = 4,
  parameter int DW    = 16,
  parameter int AW    = 3
) (
  input logic                   clk,
  input logic                   rst_n,
  rb_read_port_arbiter_if.slave rp
);
  typedef enum logic {IDLE, SEL} state_t;
  state_t           r_state, w_next;
  logic [2:0]       r_ptr, r_win, r_rd_id, w_win;
  logic [AW-1:0]    r_mux_sel, w_addr;
  logic [N_REQ-1:0] r_gnt, w_elig;
  logic             r_rd_valid, w_req_w;
  logic [DW-1:0]    r_rd_data;
  assign w_elig  = rp.req & ~r_gnt;
  assign w_req_w = |(rp.req & (N_REQ'(1) << r_win));
  always_comb begin
    w_win  = '0;
    w_addr = '0;
    for (int j = N_REQ-1; j >= 0; j--)
      if (w_elig[j]) begin
        w_win  = 3'(j);
        w_addr = rp.req_addr[j*AW +: AW];
      end
    for (int j = N_REQ-1; j >= 0; j--)
      if (w_elig[j] && 3'(j) >= r_ptr) begin
        w_win  = 3'(j);
        w_addr = rp.req_addr[j*AW +: AW];
      end
  end
  always_comb begin
    w_next = r_state;
    w_next = (r_state == SEL) ? IDLE : (|w_elig ? SEL : IDLE);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_ptr      <= '0;
      r_win      <= '0;
      r_mux_sel  <= '0;
      r_gnt      <= '0;
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
      r_rd_id    <= '0;
    end else begin
      r_state    <= w_next;
      r_gnt      <= '0;
      r_rd_valid <= 1'b0;
      if (r_state == IDLE && |w_elig) begin
        r_win     <= w_win;
        r_mux_sel <= w_addr;
      end
      if (r_state == SEL && w_req_w) begin
        r_rd_data  <= rp.mux_data;
        r_rd_id    <= r_win;
        r_gnt      <= N_REQ'(1) << r_win;
        r_rd_valid <= 1'b1;
        r_ptr      <= (r_win == 3'(N_REQ-1)) ? '0 : r_win + 3'd1;
      end
    end
  end
  assign rp.mux_sel  = r_mux_sel;
  assign rp.gnt      = r_gnt;
  assign rp.rd_valid = r_rd_valid;
  assign rp.rd_data  = r_rd_data;
  assign rp.rd_id    = r_rd_id;
  assign rp.busy     = (r_state == SEL);
endmodule
